mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multi-cycle main controller for the MIPS CPU, directly downstream of the instruction fetch unit. It consumes the `op`/`funct` fields of the fetched instruction and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives back to the fetch unit the PC write enable and next-PC selects (`Br`, `Jal`, `Jr`), and drives the datapath enables and mux selects. Supported: addu, subu, ori, lui, lw, sw, beq, jal, jr, nop (all-zero word).

## Interface
Parameters:
- none (the encodings live in the package)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op  in  6  instruction[31:26]; valid from DECODE onward
- funct  in  6  instruction[5:0]; valid from DECODE onward
- ir_we  out  1  instruction register load
- pc_we  out  1  PC update enable to the fetch unit
- Br  out  1  branch select; the fetch unit branches on `Br & zero`
- Jal  out  1  jump-to-index select
- Jr  out  1  jump-to-register select
- reg_we  out  1  GRF write enable
- reg_dst  out  2  destination: 00 rt, 01 rd, 10 $31
- alu_src  out  1  ALU B operand: 0 register, 1 extended immediate
- alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
- ext_op  out  1  immediate extension: 1 sign, 0 zero
- mem_we  out  1  DM write enable
- mem_to_reg  out  2  write-back source: 00 ALU, 01 DM, 10 pc4
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  trap indicator (see Configuration)

## Operation
- Classes: RCAL (addu, subu), ORI, LUI, LW, SW, BEQ, JAL, JR, NOP, ILL. Any op/funct combination not listed above is ILL.
- Class is decoded combinationally in DECODE and latched into `cls_q` on the DECODE→next transition.
- State sequences:
  - RCAL, ORI, LUI: F, D, E, W
  - LW: F, D, E, M, W
  - SW: F, D, E, M
  - BEQ, JAL, JR, NOP: F, D, E
- FETCH: `ir_we`=1; all other outputs 0.
- DECODE: all outputs 0.
- EXEC: ALU controls are driven per class.
  - RCAL: `alu_src`=0; `alu_op` is add or sub.
  - ORI: zero-extend, or.
  - LUI: lui.
  - LW/SW: sign-extend, add.
  - BEQ: sub, `Br`=1.
  - JAL: `Jal`=1, `reg_we`=1, `reg_dst`=10, `mem_to_reg`=10.
  - JR: `Jr`=1.
- MEM: ALU controls are held from EXEC. SW asserts `mem_we`=1.
- WB: ALU controls are held. `reg_we`=1.
  - `reg_dst`: 01 for RCAL, 00 otherwise.
  - `mem_to_reg`: 01 for LW, 00 otherwise.
- The final state of each sequence asserts `pc_we`=1 and `instr_done`=1. The PC and GRF therefore update on the same edge; the JAL link uses the pre-update pc4.
- At most one of `Br`, `Jal`, `Jr` is high in any cycle, and only together with `pc_we`.

## Timing
- All outputs are a function of the state register and `cls_q`; none depends on `op`/`funct` outside DECODE.
- While `reset`=1: all outputs are 0, and on the edge the state becomes FETCH and `cls_q` becomes NOP.
- The first cycle after `reset` falls is FETCH with `ir_we`=1.
- Reset mid-instruction aborts it. No `pc_we`, `reg_we` or `mem_we` is issued in the reset cycle.
- CPI: 3 for BEQ/JAL/JR/NOP, 4 for RCAL/ORI/LUI/SW, 5 for LW.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - ILL transitions DECODE→HALT.
  - HALT holds forever with `illegal`=1 and all enables 0. Only `reset` exits it.
- Undefined:
  - ILL executes as NOP (F, D, E, PC+4).
  - `illegal` is tied to 0 and no HALT state exists.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and funct constants
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - class encoding
  - `reg_dst`, `mem_to_reg` and `alu_op` select codes
- Sub-module `mips_ctrl_decode`: combinational op/funct→class.
- Top level `mips_mc_ctrl`: state register, `cls_q`, output logic.

## Test plan
- Reset held 2 cycles, then released → state FETCH, `ir_we`=1, all other outputs 0. Re-assert reset in the LW MEM state → next cycle all outputs 0, then FETCH.
- addu (op=0x00, funct=0x21) → `pc_we`/`instr_done` high on cycle 4 only; WB has `reg_we`=1, `reg_dst`=01, `mem_to_reg`=00, `alu_op`=000.
- lw (op=0x23) → 5 cycles; MEM has `mem_we`=0; WB has `reg_we`=1, `mem_to_reg`=01, `ext_op`=1. sw (op=0x2B) → 4 cycles, `mem_we`=1 only in MEM, never `reg_we`.
- beq (op=0x04) → cycle 3 has `Br`=1, `pc_we`=1, `alu_op`=001. jal (op=0x03) → cycle 3 has `Jal`=1, `reg_we`=1, `reg_dst`=10, `mem_to_reg`=10. jr (funct=0x08) → cycle 3 has `Jr`=1.
- nop (0x00000000) → 3 cycles, only `pc_we` in EXEC. op=0x3F: without the macro → 3 cycles, `illegal`=0; with `CTRL_ILLEGAL_TRAP_EN` → HALT, `illegal`=1 held for 20 cycles with no enables, until reset.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: opcodes, functs,
// FSM states, instruction classes and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // RCAL is split into ADDU/SUBU so the latched class alone selects alu_op.
  typedef enum logic [3:0] {
    CLS_NOP, CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_LW,
    CLS_SW, CLS_BEQ, CLS_JAL, CLS_JR, CLS_ILL
  } cls_t;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_DM   = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  // True in the last state of an instruction's sequence (PC commits there).
  function automatic logic is_final(input state_t s, input cls_t c);
    logic f;
    f = 1'b0;
    case (s)
      S_EXEC:  f = !(c inside {CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW});
      S_MEM:   f = (c == CLS_SW);
      S_WB:    f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational op/funct to instruction-class decoder for the main controller.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls
);

  always_comb begin
    o_cls = CLS_ILL;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_NOP:  o_cls = CLS_NOP;
          FN_JR:   o_cls = CLS_JR;
          FN_ADDU: o_cls = CLS_ADDU;
          FN_SUBU: o_cls = CLS_SUBU;
          default: o_cls = CLS_ILL;
        endcase
      end
      OP_JAL:  o_cls = CLS_JAL;
      OP_BEQ:  o_cls = CLS_BEQ;
      OP_ORI:  o_cls = CLS_ORI;
      OP_LUI:  o_cls = CLS_LUI;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      default: o_cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB).
// Optional illegal-instruction trap: define CTRL_ILLEGAL_TRAP_EN to enable HALT.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       ir_we,
  output logic       pc_we,
  output logic       Br,
  output logic       Jal,
  output logic       Jr,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       mem_we,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] o_dbg_state
);

  state_t r_state;
  state_t w_next;
  cls_t   r_cls_q;
  cls_t   w_cls;

  mips_ctrl_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls)
  );

  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cls_q <= CLS_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_cls_q <= w_cls;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_DECODE: w_next = (w_cls == CLS_ILL) ? S_HALT : S_EXEC;
      S_HALT:   w_next = S_HALT;
`else
      S_DECODE: w_next = S_EXEC;
`endif
      S_EXEC: begin
        case (r_cls_q)
          CLS_LW, CLS_SW:                      w_next = S_MEM;
          CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI: w_next = S_WB;
          default:                             w_next = S_FETCH;
        endcase
      end
      S_MEM:    w_next = (r_cls_q == CLS_LW) ? S_WB : S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // ALU controls are set up in EXEC and held through MEM/WB from the latched class.
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    Br         = 1'b0;
    Jal        = 1'b0;
    Jr         = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = M2R_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: ir_we = 1'b1;
        S_EXEC, S_MEM, S_WB: begin
          case (r_cls_q)
            CLS_SUBU: alu_op = ALU_SUB;
            CLS_ORI:  begin alu_src = 1'b1; alu_op = ALU_OR; end
            CLS_LUI:  begin alu_src = 1'b1; alu_op = ALU_LUI; end
            CLS_LW, CLS_SW: begin alu_src = 1'b1; ext_op = 1'b1; end
            CLS_BEQ:  alu_op = ALU_SUB;
            default:  ;
          endcase
          if (r_state == S_EXEC) begin
            case (r_cls_q)
              CLS_BEQ: Br = 1'b1;
              CLS_JAL: begin
                Jal        = 1'b1;
                reg_we     = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC4;
              end
              CLS_JR:  Jr = 1'b1;
              default: ;
            endcase
          end
          if (r_state == S_MEM && r_cls_q == CLS_SW)
            mem_we = 1'b1;
          if (r_state == S_WB) begin
            reg_we     = 1'b1;
            reg_dst    = (r_cls_q == CLS_ADDU || r_cls_q == CLS_SUBU) ? RD_RD : RD_RT;
            mem_to_reg = (r_cls_q == CLS_LW) ? M2R_DM : M2R_ALU;
          end
          if (is_final(r_state, r_cls_q)) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
          end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed literal sequences plus
// randomized instructions checked against a per-cycle behavioural model.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       ir_we, pc_we, Br, Jal, Jr, reg_we, alu_src, ext_op, mem_we;
  logic       instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [2:0] o_dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] w_got;
  logic [W-1:0] e;
  string        nm;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk (clk), .reset (reset), .op (op), .funct (funct),
    .ir_we (ir_we), .pc_we (pc_we), .Br (Br), .Jal (Jal), .Jr (Jr),
    .reg_we (reg_we), .reg_dst (reg_dst), .alu_src (alu_src), .alu_op (alu_op),
    .ext_op (ext_op), .mem_we (mem_we), .mem_to_reg (mem_to_reg),
    .instr_done (instr_done), .illegal (illegal), .o_dbg_state (o_dbg_state)
  );

  assign w_got = {ir_we, pc_we, Br, Jal, Jr, reg_we, reg_dst, alu_src, alu_op,
                  ext_op, mem_we, mem_to_reg, instr_done, illegal};

  function automatic logic [W-1:0] v(input logic ir, pc, br, jal, jr, rw,
                                     input logic [1:0] rd, input logic as_,
                                     input logic [2:0] ao, input logic eo, mw,
                                     input logic [1:0] m2r, input logic done, ill);
    return {ir, pc, br, jal, jr, rw, rd, as_, ao, eo, mw, m2r, done, ill};
  endfunction

  function automatic logic [W-1:0] fetch_v();
    return v(1, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 0);
  endfunction

  // ---------------- behavioural model ----------------
  function automatic string classify(input logic [5:0] o, input logic [5:0] f);
    string c;
    c = "ILL";
    case (o)
      6'h00: case (f)
               6'h21: c = "ADDU";
               6'h23: c = "SUBU";
               6'h08: c = "JR";
               6'h00: c = "NOP";
               default: c = "ILL";
             endcase
      6'h0D: c = "ORI";
      6'h0F: c = "LUI";
      6'h23: c = "LW";
      6'h2B: c = "SW";
      6'h04: c = "BEQ";
      6'h03: c = "JAL";
      default: c = "ILL";
    endcase
    return c;
  endfunction

  function automatic int cpi(input string c);
    if (c == "LW") return 5;
    if (c == "ADDU" || c == "SUBU" || c == "ORI" || c == "LUI" || c == "SW") return 4;
    return 3;
  endfunction

  // Outputs expected in cycle i (0 = fetch) of an n-cycle instruction of class c.
  function automatic logic [W-1:0] model_vec(input string c, input int i, input int n);
    logic ir, pc, br, jal, jr, rw, as_, eo, mw, done;
    logic [1:0] rd, m2r;
    logic [2:0] ao;
    {ir, pc, br, jal, jr, rw, as_, eo, mw, done} = '0;
    rd = 2'd0; m2r = 2'd0; ao = 3'd0;
    if (i == 0) ir = 1'b1;
    if (i >= 2) begin
      if (c == "SUBU" || c == "BEQ") ao = 3'd1;
      if (c == "ORI") begin as_ = 1'b1; ao = 3'd2; end
      if (c == "LUI") begin as_ = 1'b1; ao = 3'd3; end
      if (c == "LW" || c == "SW") begin as_ = 1'b1; eo = 1'b1; end
    end
    if (i == 2 && c == "BEQ") br = 1'b1;
    if (i == 2 && c == "JR")  jr = 1'b1;
    if (i == 2 && c == "JAL") begin jal = 1'b1; rw = 1'b1; rd = 2'd2; m2r = 2'd2; end
    if (i == 3 && c == "SW")  mw = 1'b1;
    if (i == n - 1 && i >= 3 && c != "SW") begin
      rw  = 1'b1;
      rd  = (c == "ADDU" || c == "SUBU") ? 2'd1 : 2'd0;
      m2r = (c == "LW") ? 2'd1 : 2'd0;
    end
    if (i == n - 1) begin pc = 1'b1; done = 1'b1; end
    return v(ir, pc, br, jal, jr, rw, rd, as_, ao, eo, mw, m2r, done, 1'b0);
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (w_got !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, w_got, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] ev, input string name);
    exp_q.push_back(ev);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    step('0, name);
    reset = 1'b0;
  endtask

  task automatic run_model(input logic [5:0] o, input logic [5:0] f, input int abort_at);
    string c;
    int n;
    c = classify(o, f);
    n = cpi(c);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      if (i == 1) begin op = o; funct = f; end
      else begin op = 6'($urandom); funct = 6'($urandom); end
      step(model_vec(c, i, n), c);
    end
    if (abort_at >= 0 && abort_at < n) do_reset("rst_abort");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ro, rf;
    int sel, ab;
    @(posedge clk);
    #1;
    step('0, "rst_hold0");
    step('0, "rst_hold1");
    reset = 1'b0;
    #1;
    checks++;
    if (o_dbg_state !== S_FETCH) begin
      errors++;
      $display("FAIL dbg_state_after_reset got=%0d exp=%0d", o_dbg_state, S_FETCH);
    end
    #0;

    // addu
    op = 6'h00; funct = 6'h21;
    step(fetch_v(), "addu_F");
    step('0, "addu_D");
    step('0, "addu_E");
    step(v(0, 1, 0, 0, 0, 1, 2'd1, 0, 3'd0, 0, 0, 2'd0, 1, 0), "addu_W");
    // subu
    funct = 6'h23;
    step(fetch_v(), "subu_F");
    step('0, "subu_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd1, 0, 0, 2'd0, 0, 0), "subu_E");
    step(v(0, 1, 0, 0, 0, 1, 2'd1, 0, 3'd1, 0, 0, 2'd0, 1, 0), "subu_W");
    // lw
    op = 6'h23; funct = 6'h15;
    step(fetch_v(), "lw_F");
    step('0, "lw_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd0, 1, 0, 2'd0, 0, 0), "lw_E");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd0, 1, 0, 2'd0, 0, 0), "lw_M");
    step(v(0, 1, 0, 0, 0, 1, 2'd0, 1, 3'd0, 1, 0, 2'd1, 1, 0), "lw_W");
    // sw
    op = 6'h2B;
    step(fetch_v(), "sw_F");
    step('0, "sw_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd0, 1, 0, 2'd0, 0, 0), "sw_E");
    step(v(0, 1, 0, 0, 0, 0, 2'd0, 1, 3'd0, 1, 1, 2'd0, 1, 0), "sw_M");
    // beq
    op = 6'h04;
    step(fetch_v(), "beq_F");
    step('0, "beq_D");
    step(v(0, 1, 1, 0, 0, 0, 2'd0, 0, 3'd1, 0, 0, 2'd0, 1, 0), "beq_E");
    // jal
    op = 6'h03;
    step(fetch_v(), "jal_F");
    step('0, "jal_D");
    step(v(0, 1, 0, 1, 0, 1, 2'd2, 0, 3'd0, 0, 0, 2'd2, 1, 0), "jal_E");
    // jr
    op = 6'h00; funct = 6'h08;
    step(fetch_v(), "jr_F");
    step('0, "jr_D");
    step(v(0, 1, 0, 0, 1, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0), "jr_E");
    // nop
    funct = 6'h00;
    step(fetch_v(), "nop_F");
    step('0, "nop_D");
    step(v(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0), "nop_E");
    // ori, lui
    op = 6'h0D;
    step(fetch_v(), "ori_F");
    step('0, "ori_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd2, 0, 0, 2'd0, 0, 0), "ori_E");
    step(v(0, 1, 0, 0, 0, 1, 2'd0, 1, 3'd2, 0, 0, 2'd0, 1, 0), "ori_W");
    op = 6'h0F;
    step(fetch_v(), "lui_F");
    step('0, "lui_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd3, 0, 0, 2'd0, 0, 0), "lui_E");
    step(v(0, 1, 0, 0, 0, 1, 2'd0, 1, 3'd3, 0, 0, 2'd0, 1, 0), "lui_W");
    // lw aborted by reset in MEM, then a fresh fetch
    op = 6'h23;
    step(fetch_v(), "lwab_F");
    step('0, "lwab_D");
    step(v(0, 0, 0, 0, 0, 0, 2'd0, 1, 3'd0, 1, 0, 2'd0, 0, 0), "lwab_E");
    do_reset("lwab_rst");
    op = 6'h04;
    step(fetch_v(), "post_rst_F");
    step('0, "post_rst_D");
    step(v(0, 1, 1, 0, 0, 0, 2'd0, 0, 3'd1, 0, 0, 2'd0, 1, 0), "post_rst_E");
    // illegal opcode
    op = 6'h3F; funct = 6'h00;
    step(fetch_v(), "ill_F");
    step('0, "ill_D");
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 20; k++)
      step(v(0, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 0, 1), "ill_HALT");
    do_reset("ill_rst");
`else
    step(v(0, 1, 0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 2'd0, 1, 0), "ill_E");
`endif

    // randomized instruction stream against the model
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 11);
      rf  = 6'($urandom);
      case (sel)
        0:  begin ro = 6'h00; rf = 6'h21; end
        1:  begin ro = 6'h00; rf = 6'h23; end
        2:  ro = 6'h0D;
        3:  ro = 6'h0F;
        4:  ro = 6'h23;
        5:  ro = 6'h2B;
        6:  ro = 6'h04;
        7:  ro = 6'h03;
        8:  begin ro = 6'h00; rf = 6'h08; end
        9:  begin ro = 6'h00; rf = 6'h00; end
        10: ro = 6'h00;
        default: ro = 6'($urandom);
      endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (classify(ro, rf) == "ILL") begin ro = 6'h00; rf = 6'h00; end
`endif
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, cpi(classify(ro, rf)) - 1) : -1;
      run_model(ro, rf, ab);
    end

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
